// File: rtl/fault_inj_pkg.sv
// Shared definitions for the fault injector: mode encodings, LFSR seed/taps and
// the LFSR step function used when random start indices are enabled.
package fault_inj_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_SINGLE = 2'd1,
    MODE_DOUBLE = 2'd2,
    MODE_BURST  = 2'd3
  } mode_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/fault_mask_gen.sv
// Combinational fault mask: run of L bits starting at index a, wrapping modulo
// CODE_W. Zero latency, no flow control.
module fault_mask_gen
  import fault_inj_pkg::*;
#(
  parameter int CODE_W = 12,
  parameter int ADDR_W = $clog2(CODE_W)
) (
  input  mode_t             mode,
  input  logic [ADDR_W-1:0] start,
  input  logic [ADDR_W:0]   len,
  output logic [CODE_W-1:0] mask
);

  int run_len;
  int offset;

  always_comb begin
    mask    = '0;
    run_len = 0;
    offset  = 0;
    case (mode)
      MODE_SINGLE: run_len = 1;
      MODE_DOUBLE: run_len = 2;
      MODE_BURST:  run_len = (int'(len) > CODE_W) ? CODE_W : int'(len);
      default:     run_len = 0;
    endcase
    // Out-of-range start index disables injection entirely rather than wrapping
    if (int'(start) < CODE_W) begin
      for (int i = 0; i < CODE_W; i++) begin
        offset = (i >= int'(start)) ? (i - int'(start)) : (i + CODE_W - int'(start));
        if (offset < run_len) mask[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fault_injector.sv
// Single registered stage flipping configured bits on every Nth word (1-cycle latency,
// stalls input only while the held word is not taken). Macro FAULT_INJ_LFSR_EN adds a random start index.
module fault_injector
  import fault_inj_pkg::*;
#(
  parameter int CODE_W = 12,
  parameter int ADDR_W = $clog2(CODE_W),
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [CODE_W-1:0] out_fault_mask,
  input  logic [1:0]        cfg_mode,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [ADDR_W:0]   cfg_burst_len,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic              cfg_rand,
  output logic [CNT_W-1:0]  fault_cnt
);

  logic              accept;
  logic              candidate;
  logic [CNT_W-1:0]  period_cnt;
  logic [ADDR_W-1:0] start_idx;
  logic [CODE_W-1:0] mask;
  mode_t             mode_eff;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // >= rather than == so a period shrunk below the running count cannot stall injection
  assign candidate = (cfg_period == '0) || (period_cnt >= cfg_period - CNT_W'(1));
  assign mode_eff  = candidate ? mode_t'(cfg_mode) : MODE_OFF;

`ifdef FAULT_INJ_LFSR_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (accept) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign start_idx = cfg_rand ? ADDR_W'(lfsr % 16'(CODE_W)) : cfg_addr;
`else
  logic unused_rand;
  assign unused_rand = cfg_rand;
  assign start_idx   = cfg_addr;
`endif

  fault_mask_gen #(
    .CODE_W (CODE_W),
    .ADDR_W (ADDR_W)
  ) u_mask_gen (
    .mode  (mode_eff),
    .start (start_idx),
    .len   (cfg_burst_len),
    .mask  (mask)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_code       <= '0;
      out_fault_mask <= '0;
      fault_cnt      <= '0;
      period_cnt     <= '0;
    end else begin
      if (accept) begin
        out_valid      <= 1'b1;
        out_code       <= in_code ^ mask;
        out_fault_mask <= mask;
        period_cnt     <= candidate ? '0 : period_cnt + CNT_W'(1);
        if ((|mask) && (fault_cnt != '1)) fault_cnt <= fault_cnt + CNT_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  hold_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_code) && $stable(out_fault_mask)));

endmodule

// File: doc/fault_injector.md
FAULT_INJECTOR -- requirements
Module: fault_injector

Interface
REQ-001 SHALL have parameter CODE_W, default 12, meaning codeword width in bits (legal 4..64).
REQ-002 SHALL have parameter ADDR_W, default $clog2(CODE_W), meaning bit-index width.
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of the period and fault counters.
REQ-004 SHALL have ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when both are high.
- in_code  in  CODE_W  clean codeword.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts.
- out_code  out  CODE_W  codeword with faults applied.
- out_fault_mask  out  CODE_W  bits flipped in out_code.
- cfg_mode  in  2  0 off, 1 single, 2 double-adjacent, 3 burst.
- cfg_addr  in  ADDR_W  first faulted bit index.
- cfg_burst_len  in  ADDR_W+1  burst length (mode 3).
- cfg_period  in  CNT_W  inject on every Nth accepted word.
- cfg_rand  in  1  use pseudo-random start index (see Configuration).
- fault_cnt  out  CNT_W  count of words emitted with a non-zero mask.

Function
REQ-005 SHALL be a single registered stage: in_ready = !out_valid || out_ready; a word accepted in cycle N appears on out_code at N+1.
REQ-006 SHALL hold out_code, out_fault_mask and out_valid stable while out_valid=1 and out_ready=0.
REQ-007 SHALL sample all cfg_* inputs only in the accepting cycle; cfg changes never alter a held output.
REQ-008 SHALL keep a period counter, incremented per accepted word; the word is an injection candidate when counter == cfg_period-1, and the counter then returns to 0.
REQ-009 SHALL treat cfg_period=0 as 1 (every word is a candidate).
REQ-010 SHALL build the mask for a candidate word as: mode 0 all-zero; mode 1 bit a; mode 2 bits a and (a+1) mod CODE_W; mode 3 bits a..a+L-1 mod CODE_W, L=min(cfg_burst_len, CODE_W).
REQ-011 SHALL produce an all-zero mask when the start index a >= CODE_W, when mode 3 has L=0, or when the word is not a candidate.
REQ-012 SHALL output out_code = in_code XOR mask and out_fault_mask = mask.
REQ-013 SHALL increment fault_cnt by one per accepted word with a non-zero mask, saturating at all-ones.
REQ-014 SHALL accept and emit in the same cycle when out_valid=1, out_ready=1 and in_valid=1, with no bubble.

Reset
REQ-015 SHALL, while rst_n=0, set out_valid=0, out_code=0, out_fault_mask=0, fault_cnt=0, period counter=0, LFSR=16'hACE1.
REQ-016 SHALL, on reset mid-transfer, discard the held word; in_ready=1 in the first cycle after release.

Configuration
REQ-017 SHALL, with macro FAULT_INJ_LFSR_EN defined, contain a 16-bit Fibonacci LFSR (taps 16,14,13,11) advancing once per accepted word; when cfg_rand=1, start index a = LFSR mod CODE_W, else a = cfg_addr.
REQ-018 SHALL, without FAULT_INJ_LFSR_EN, contain no LFSR, ignore cfg_rand, and always use a = cfg_addr.

Structure
REQ-019 SHALL place the mode encodings (MODE_OFF/SINGLE/DOUBLE/BURST), the LFSR seed and the LFSR taps in shared package fault_inj_pkg.
REQ-020 SHALL implement mask generation in sub-module fault_mask_gen (combinational: mode, a, L -> CODE_W mask).

Verification
REQ-021 Mode 1, addr=3, period=1, in_code=12'h000 -> out_code=12'h008, mask=12'h008, fault_cnt=1.
REQ-022 Mode 2, addr=11, CODE_W=12, in_code=12'hFFF -> mask=12'h801 (wrap), out_code=12'h7FE.
REQ-023 Mode 3, addr=2, burst_len=4, period=3, five words of 12'h000 -> only the 3rd word has mask=12'h03C; fault_cnt=1.
REQ-024 out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0, output held unchanged; second word appears one cycle after out_ready rises.
REQ-025 addr=12 (>=CODE_W) or mode 3 with burst_len=0 -> mask=0, fault_cnt unchanged.
REQ-026 rst_n pulsed low mid-stream -> out_valid=0 and fault_cnt=0 during the pulse; with FAULT_INJ_LFSR_EN and cfg_rand=1, the start-index sequence restarts from seed 16'hACE1.
